systolic_output_collector: RTL and testbench

- Downstream stage of the brightness-filter systolic array; consumes the skewed accumulator outputs of the bottom-row MAC cells.
- Column j result arrives j cycles after column 0. The block de-skews the columns, applies the brightness fixed-point scale (round, shift, clamp to pixel range) and buffers complete pixel vectors.
- Emits vectors on a valid/ready stream with an end-of-frame marker.

---
 rtl/brightness_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 57 +++++
 rtl/systolic_output_collector.sv | 134 +++++++++++++
 tb/tb_systolic_output_collector.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/brightness_pkg.sv
// Shared constants and the fixed-point scale/clamp helper for the brightness-filter output path.
package brightness_pkg;

   localparam int ACC_WIDTH_DEF = 32;
   localparam int PIX_WIDTH_DEF = 8;
   localparam int SHIFT_DEF     = 4;
   localparam int ACC_WIDTH_MAX = 64;
   localparam int PIX_WIDTH_MAX = 32;
   localparam int ACC_EXT_W     = ACC_WIDTH_MAX + 1;

   localparam logic [PIX_WIDTH_DEF-1:0] PIX_MAX = '1;

   typedef struct packed {
      logic                     sat;
      logic [PIX_WIDTH_MAX-1:0] pix;
   } scale_res_t;

   // One extra bit of headroom so the rounding add cannot wrap for any accumulator up to ACC_WIDTH_MAX.
   function automatic scale_res_t sat_scale(input logic [ACC_WIDTH_MAX-1:0] acc,
                                            input int                      shift,
                                            input int                      pix_w);
      logic [ACC_EXT_W-1:0] rnd;
      logic [ACC_EXT_W-1:0] sum;
      logic [ACC_EXT_W-1:0] p;
      logic [ACC_EXT_W-1:0] lim;
      scale_res_t           res;
      rnd     = (shift > 0) ? (ACC_EXT_W'(1) << (shift - 1)) : '0;
      sum     = {1'b0, acc} + rnd;
      p       = sum >> shift;
      lim     = (ACC_EXT_W'(1) << pix_w) - ACC_EXT_W'(1);
      res.sat = (p > lim);
      res.pix = PIX_WIDTH_MAX'(res.sat ? lim : p);
      return res;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; push and pop together on full is allowed.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/systolic_output_collector.sv
// De-skews bottom-row accumulators, scales/clamps them to pixels and streams whole vectors with frame markers.
module systolic_output_collector
   import brightness_pkg::*;
#(
   parameter int COLS          = 4,
   parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
   parameter int PIX_WIDTH     = PIX_WIDTH_DEF,
   parameter int SHIFT         = SHIFT_DEF,
   parameter int DEPTH         = 8,
   parameter int FRAME_VECTORS = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [COLS*ACC_WIDTH-1:0] acc_in,
   output logic                      in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [COLS*PIX_WIDTH-1:0] out_pixels,
   output logic                      out_last,
   output logic                      sat_flag,
   output logic                      drop_flag
);

   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int FC_W   = (FRAME_VECTORS > 1) ? $clog2(FRAME_VECTORS) : 1;
   localparam int FIFO_W = COLS * PIX_WIDTH + 1;

   logic                      accept;
   logic                      push;
   logic                      pop;
   logic [COLS-2:0]           vld_p;
   logic [COLS*ACC_WIDTH-1:0] col_al;
   logic [COLS*PIX_WIDTH-1:0] pix_s;
   logic [COLS-1:0]           sat_s;
   logic [FC_W-1:0]           frame_cnt;
   logic                      last_s;
   logic [FIFO_W-1:0]         head;
   logic                      fifo_empty;
   logic                      fifo_full;
   logic [CNT_W-1:0]          fifo_count;
   logic                      ready_nxt;

   assign accept = in_valid && in_ready;
   assign push   = vld_p[COLS-2];
   assign pop    = out_valid && out_ready;

   // Stage 0..COLS-2: per-column delay lines; column j waits COLS-1-j cycles so all meet column COLS-1.
   for (genvar j = 0; j < COLS; j++) begin : g_col
      if (j == COLS - 1) begin : g_direct
         assign col_al[j*ACC_WIDTH +: ACC_WIDTH] = acc_in[j*ACC_WIDTH +: ACC_WIDTH];
      end else begin : g_delay
         logic [ACC_WIDTH-1:0] dly_p [COLS-1-j];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int k = 0; k < COLS - 1 - j; k++) dly_p[k] <= '0;
            end else begin
               dly_p[0] <= acc_in[j*ACC_WIDTH +: ACC_WIDTH];
               for (int k = 1; k < COLS - 1 - j; k++) dly_p[k] <= dly_p[k-1];
            end
         end
         assign col_al[j*ACC_WIDTH +: ACC_WIDTH] = dly_p[COLS-2-j];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= accept;
         for (int k = 1; k < COLS - 1; k++) vld_p[k] <= vld_p[k-1];
      end
   end

   // Scale stage: aligned vector is rounded, shifted and clamped; the FIFO entry is its register.
   always_comb begin
      scale_res_t res;
      res   = '0;
      pix_s = '0;
      sat_s = '0;
      for (int j = 0; j < COLS; j++) begin
         res = sat_scale(ACC_WIDTH_MAX'(col_al[j*ACC_WIDTH +: ACC_WIDTH]), SHIFT, PIX_WIDTH);
         pix_s[j*PIX_WIDTH +: PIX_WIDTH] = PIX_WIDTH'(res.pix);
         sat_s[j] = res.sat;
      end
   end

   assign last_s = (frame_cnt == FC_W'(FRAME_VECTORS - 1));

   // Credits count what the FIFO will hold once everything in flight lands, including this cycle's accept.
   always_comb begin
      int credits;
      credits   = int'(fifo_count) + $countones(vld_p) + int'(accept) - int'(pop);
      ready_nxt = (credits < DEPTH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         sat_flag  <= 1'b0;
         drop_flag <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         if (push) frame_cnt <= last_s ? '0 : frame_cnt + FC_W'(1);
         sat_flag  <= sat_flag | (push & (|sat_s));
         drop_flag <= drop_flag | (in_valid & ~in_ready);
         in_ready  <= ready_nxt;
      end
   end

   sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (DEPTH)
   ) u_out_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .wr_data ({last_s, pix_s}),
      .rd_en   (pop),
      .rd_data (head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign out_valid  = !fifo_empty;
   assign out_pixels = head[COLS*PIX_WIDTH-1:0];
   assign out_last   = out_valid & head[FIFO_W-1];

   always_ff @(posedge clk) begin
      if (!reset) assert (!(push && fifo_full));
   end

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for systolic_output_collector: skewed column driver, expected-vector queue and output monitor.
module tb_systolic_output_collector;

   localparam int COLS          = 4;
   localparam int ACC_WIDTH     = 32;
   localparam int PIX_WIDTH     = 8;
   localparam int SHIFT         = 4;
   localparam int DEPTH         = 8;
   localparam int FRAME_VECTORS = 4;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      in_valid;
   logic [COLS*ACC_WIDTH-1:0] acc_in;
   logic                      in_ready;
   logic                      out_valid;
   logic                      out_ready;
   logic [COLS*PIX_WIDTH-1:0] out_pixels;
   logic                      out_last;
   logic                      sat_flag;
   logic                      drop_flag;

   int checks   = 0;
   int failures = 0;
   int fcnt     = 0;
   int popped   = 0;
   int acc_cnt  = 0;

   logic [32:0]  exp_q [$];
   logic [32:0]  mon_exp;
   logic [127:0] hist [4];

   always #5 clk = ~clk;

   systolic_output_collector #(
      .COLS          (COLS),
      .ACC_WIDTH     (ACC_WIDTH),
      .PIX_WIDTH     (PIX_WIDTH),
      .SHIFT         (SHIFT),
      .DEPTH         (DEPTH),
      .FRAME_VECTORS (FRAME_VECTORS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .acc_in     (acc_in),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pixels (out_pixels),
      .out_last   (out_last),
      .sat_flag   (sat_flag),
      .drop_flag  (drop_flag)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One clock of stimulus: column j on the bus carries the vector whose column 0 went out j cycles earlier.
   task automatic cyc(input logic v, input logic [127:0] vec, input logic [31:0] px);
      @(posedge clk);
      #1;
      for (int d = 3; d > 0; d--) hist[d] = hist[d-1];
      hist[0]  = v ? vec : '0;
      in_valid = v;
      for (int j = 0; j < COLS; j++) acc_in[j*32 +: 32] = hist[j][j*32 +: 32];
      if (v && in_ready && !reset) begin
         exp_q.push_back({(fcnt == FRAME_VECTORS - 1), px});
         fcnt = (fcnt == FRAME_VECTORS - 1) ? 0 : fcnt + 1;
         acc_cnt++;
      end
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < max_cycles) begin
         cyc(1'b0, '0, '0);
         n++;
      end
      chk("drain_done", 64'(exp_q.size() == 0 && !out_valid), 64'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      fcnt = 0;
      cyc(1'b0, '0, '0);
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         popped++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_vector actual=%0h required=none", {out_last, out_pixels});
         end else begin
            mon_exp = exp_q.pop_front();
            chk("out_vector", 64'({out_last, out_pixels}), 64'(mon_exp));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] vec;
      logic [31:0]  px;
      logic [11:0]  ov_h;
      logic [11:0]  lst_h;
      logic [11:0]  rdy_h;
      int           p0;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      acc_in    = '0;
      for (int d = 0; d < 4; d++) hist[d] = '0;

      cyc(1'b0, '0, '0);
      cyc(1'b0, '0, '0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_sat_flag", 64'(sat_flag), 64'd0);
      chk("rst_drop_flag", 64'(drop_flag), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_pixels", 64'(out_pixels), 64'd0);
      reset = 1'b0;

      // Single vector, latency of exactly COLS cycles
      out_ready = 1'b1;
      cyc(1'b1, {4{32'h100}}, 32'h10101010);
      repeat (3) cyc(1'b0, '0, '0);
      chk("latency_early", 64'(out_valid), 64'd0);
      cyc(1'b0, '0, '0);
      chk("latency_on_time", 64'(out_valid), 64'd1);
      drain(20);
      chk("single_sat_flag", 64'(sat_flag), 64'd0);

      // Rounding boundaries, exact 0xFF without clamp, then clamps including the all-ones accumulator
      cyc(1'b1, {32'h10, 32'hFF7, 32'h18, 32'h17}, {8'h01, 8'hFF, 8'h02, 8'h01});
      drain(20);
      chk("round_sat_flag_clear", 64'(sat_flag), 64'd0);
      cyc(1'b1, {32'hFFFF_FFFF, 32'h1000, 32'h0, 32'h7}, {8'hFF, 8'hFF, 8'h00, 8'h00});
      drain(20);
      chk("clamp_sat_flag_set", 64'(sat_flag), 64'd1);

      // Back-to-back streaming from a fresh frame
      do_reset();
      chk("reset_clears_sat", 64'(sat_flag), 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         vec = '0;
         px  = '0;
         for (int j = 0; j < COLS; j++) begin
            vec[j*32 +: 32] = 32'((i * 16 + j + 1) * 16);
            px[j*8 +: 8]    = 8'(i * 16 + j + 1);
         end
         cyc(i < 8, vec, px);
         ov_h[i]  = out_valid;
         lst_h[i] = out_last;
      end
      chk("stream_valid_run", 64'(ov_h), 64'hFF0);
      chk("stream_last_pos", 64'(lst_h), 64'h880);
      drain(20);

      // Backpressure: credits allow exactly DEPTH vectors, the rest are dropped
      out_ready = 1'b0;
      acc_cnt   = 0;
      for (int i = 0; i < 12; i++) begin
         vec = '0;
         px  = '0;
         for (int j = 0; j < COLS; j++) begin
            vec[j*32 +: 32] = 32'((32 + i * 4 + j) * 16);
            px[j*8 +: 8]    = 8'(32 + i * 4 + j);
         end
         cyc(1'b1, vec, px);
         rdy_h[i] = in_ready;
      end
      cyc(1'b0, '0, '0);
      chk("bp_accepted", 64'(acc_cnt), 64'd8);
      chk("bp_ready_pattern", 64'(rdy_h), 64'h0FF);
      chk("bp_in_ready_held", 64'(in_ready), 64'd0);
      chk("bp_drop_flag", 64'(drop_flag), 64'd1);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      p0        = popped;
      out_ready = 1'b1;
      drain(40);
      chk("bp_drained", 64'(popped - p0), 64'd8);

      // Reset while a vector is in flight; frame counter restarts afterwards
      cyc(1'b1, {32'hFFFF, 32'h0, 32'h0, 32'h0}, {8'hFF, 8'h00, 8'h00, 8'h00});
      drain(20);
      chk("pre_reset_sat", 64'(sat_flag), 64'd1);
      cyc(1'b1, {4{32'h555}}, {4{8'h55}});
      cyc(1'b0, '0, '0);
      cyc(1'b0, '0, '0);
      do_reset();
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_sat_flag", 64'(sat_flag), 64'd0);
      chk("midrst_drop_flag", 64'(drop_flag), 64'd0);
      repeat (5) cyc(1'b0, '0, '0);
      chk("midrst_discarded", 64'(out_valid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, {4{32'((i + 1) * 256)}}, {4{8'((i + 1) * 16)}});
      end
      drain(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
